// File: rtl/l2_multi_chan_read_server.sv
// L2 buffer read server: NUM_CH round-robin read channels over one single-port array,
// preload writes take priority, fixed RD_LAT read pipeline and a saturating stall counter.
module l2_multi_chan_read_server #(
   parameter int DATA_W    = 64,
   parameter int ROWS_LOG2 = 10,
   parameter int NUM_CH    = 2,
   parameter int RD_LAT    = 2
) (
   input  logic                        core_clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [ROWS_LOG2-1:0]        wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic [NUM_CH-1:0]           rd_ready,
   input  logic [NUM_CH*ROWS_LOG2-1:0] rd_addr,
   output logic [NUM_CH-1:0]           rd_grant,
   output logic [NUM_CH-1:0]           rd_valid,
   output logic [NUM_CH*DATA_W-1:0]    rd_data,
   output logic [15:0]                 stall_cnt
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DEPTH = 1 << ROWS_LOG2;
   localparam int PIPE  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
   localparam int TAIL  = (RD_LAT > 1) ? RD_LAT - 2 : 0;

   logic [DATA_W-1:0]        r_mem [DEPTH];
   logic [CH_W-1:0]          r_rr;
   logic [15:0]              r_stall;
   logic [NUM_CH-1:0]        r_valid;
   logic [NUM_CH*DATA_W-1:0] r_data;

   logic                     r_pv  [PIPE];
   logic [CH_W-1:0]          r_pch [PIPE];
   logic [DATA_W-1:0]        r_pd  [PIPE];

   logic                     w_gnt_v;
   logic [CH_W-1:0]          w_gnt_ch;
   logic [ROWS_LOG2-1:0]     w_gnt_addr;
   logic [NUM_CH-1:0]        w_gnt;
   logic [DATA_W-1:0]        w_gnt_data;
   logic                     w_tail_v;
   logic [CH_W-1:0]          w_tail_ch;
   logic [DATA_W-1:0]        w_tail_d;

   // Pass 0 scans channels at or above the pointer, pass 1 wraps to those below it.
   always_comb begin
      w_gnt_v    = 1'b0;
      w_gnt_ch   = '0;
      w_gnt_addr = '0;
      w_gnt      = '0;
      if (rst_n && !wr_en) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (!w_gnt_v && rd_ready[c] &&
                   ((pass == 0) ? (c >= int'(r_rr)) : (c < int'(r_rr)))) begin
                  w_gnt_v    = 1'b1;
                  w_gnt_ch   = CH_W'(c);
                  w_gnt_addr = rd_addr[c*ROWS_LOG2 +: ROWS_LOG2];
                  w_gnt[c]   = 1'b1;
               end
            end
         end
      end
   end

   assign w_gnt_data = r_mem[w_gnt_addr];
   assign rd_grant   = w_gnt;

   always_ff @(posedge core_clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr <= '0;
      end else if (w_gnt_v) begin
         r_rr <= (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;
      end
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall <= '0;
      end else if ((|rd_ready) && !w_gnt_v && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   // Row data is captured at grant time so later writes cannot alter in-flight reads.
   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < PIPE; p++) begin
            r_pv[p]  <= 1'b0;
            r_pch[p] <= '0;
            r_pd[p]  <= '0;
         end
      end else begin
         r_pv[0]  <= w_gnt_v;
         r_pch[0] <= w_gnt_ch;
         r_pd[0]  <= w_gnt_data;
         for (int p = 1; p < PIPE; p++) begin
            r_pv[p]  <= r_pv[p-1];
            r_pch[p] <= r_pch[p-1];
            r_pd[p]  <= r_pd[p-1];
         end
      end
   end

   assign w_tail_v  = (RD_LAT > 1) ? r_pv[TAIL]  : w_gnt_v;
   assign w_tail_ch = (RD_LAT > 1) ? r_pch[TAIL] : w_gnt_ch;
   assign w_tail_d  = (RD_LAT > 1) ? r_pd[TAIL]  : w_gnt_data;

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_tail_v && (w_tail_ch == CH_W'(c))) begin
               r_valid[c]                  <= 1'b1;
               r_data[c*DATA_W +: DATA_W]  <= w_tail_d;
            end
         end
      end
   end

   assign rd_valid  = r_valid;
   assign rd_data   = r_data;
   assign stall_cnt = r_stall;

endmodule

// File: tb/tb_l2_multi_chan_read_server.sv
// Directed bench for l2_multi_chan_read_server: driver pushes expected read responses
// (due cycle, channel, data) at grant time; a negedge monitor pops and compares them.
module tb_l2_multi_chan_read_server;
  localparam int DW  = 64;
  localparam int AW  = 10;
  localparam int NCH = 2;
  localparam int LAT = 2;
  localparam int EW  = 32 + NCH + DW;

  logic              core_clk;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NCH-1:0]    rd_ready;
  logic [NCH*AW-1:0] rd_addr;
  logic [NCH-1:0]    rd_grant;
  logic [NCH-1:0]    rd_valid;
  logic [NCH*DW-1:0] rd_data;
  logic [15:0]       stall_cnt;

  int unsigned       cyc;
  int                n_tests;
  int                n_fail;
  logic [EW-1:0]     exp_q[$];

  l2_multi_chan_read_server #(
    .DATA_W(DW), .ROWS_LOG2(AW), .NUM_CH(NCH), .RD_LAT(LAT)
  ) dut (
    .core_clk  (core_clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rd_grant  (rd_grant),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial begin
    core_clk = 1'b0;
    cyc      = 0;
    forever #5 core_clk = ~core_clk;
  end

  always @(posedge core_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver: called at posedge+1, applies inputs for one cycle and checks the grant
  task automatic drive_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic [NCH-1:0] rdy, input logic [AW-1:0] a0,
                             input logic [AW-1:0] a1, input logic [NCH-1:0] eg,
                             input logic [DW-1:0] ed);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_ready = rdy;
    rd_addr  = {a1, a0};
    @(negedge core_clk);
    check("rd_grant", {126'b0, rd_grant}, {126'b0, eg});
    if (eg != '0) exp_q.push_back({cyc + LAT, eg, ed});
    @(posedge core_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, '0, '0, 2'b00, '0, '0, 2'b00, '0);
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [DW-1:0] d;
    forever begin
      @(negedge core_clk);
      if (rd_valid != '0) begin
        d = rd_valid[1] ? rd_data[2*DW-1:DW] : rd_data[DW-1:0];
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {126'b0, rd_valid}, 128'b0);
        end else begin
          e = exp_q.pop_front();
          check("read_resp(cyc,valid,data)", {30'b0, cyc, rd_valid, d}, {30'b0, e});
        end
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_ready = 2'b11;
    rd_addr  = '0;
    repeat (2) @(negedge core_clk);
    check("reset_grant", {126'b0, rd_grant}, 128'b0);
    check("reset_valid", {126'b0, rd_valid}, 128'b0);
    check("reset_data", rd_data, 128'b0);
    check("reset_stall", {112'b0, stall_cnt}, 128'b0);
    rd_ready = 2'b00;
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;

    // preload rows 0..3
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, AW'(i), 64'h11 * (i + 1), 2'b00, '0, '0, 2'b00, '0);

    // single reads, rr moves 0 -> 1 -> 0
    drive_cycle(1'b0, '0, '0, 2'b01, 10'd2, '0, 2'b01, 64'h33);
    drive_cycle(1'b0, '0, '0, 2'b10, '0, 10'd3, 2'b10, 64'h44);
    idle(3);
    check("rd_data_hold", rd_data, {64'h44, 64'h33});

    // both channels contend: strict alternation
    drive_cycle(1'b0, '0, '0, 2'b11, 10'd0, 10'd1, 2'b01, 64'h11);
    drive_cycle(1'b0, '0, '0, 2'b11, 10'd0, 10'd1, 2'b10, 64'h22);
    drive_cycle(1'b0, '0, '0, 2'b11, 10'd0, 10'd1, 2'b01, 64'h11);
    drive_cycle(1'b0, '0, '0, 2'b11, 10'd0, 10'd1, 2'b10, 64'h22);
    idle(1);
    check("stall_after_alt", {112'b0, stall_cnt}, 128'd0);

    // write beats a pending ch1 read of the same row
    drive_cycle(1'b1, 10'd1, 64'hAA, 2'b10, '0, 10'd1, 2'b00, '0);
    check("stall_write_prio", {112'b0, stall_cnt}, 128'd1);
    drive_cycle(1'b0, '0, '0, 2'b10, '0, 10'd1, 2'b10, 64'hAA);

    // in-flight read keeps grant-time data despite a following write
    drive_cycle(1'b0, '0, '0, 2'b01, 10'd1, '0, 2'b01, 64'hAA);
    drive_cycle(1'b1, 10'd1, 64'hBB, 2'b00, '0, '0, 2'b00, '0);
    drive_cycle(1'b0, '0, '0, 2'b01, 10'd1, '0, 2'b01, 64'hBB);
    check("stall_unchanged", {112'b0, stall_cnt}, 128'd1);

    // reset one cycle after a ch0 grant (rr would be 1): in-flight reads dropped
    drive_cycle(1'b0, '0, '0, 2'b01, 10'd0, '0, 2'b01, 64'h11);
    rd_ready = 2'b00;
    rst_n    = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge core_clk);
      check("valid_in_reset", {126'b0, rd_valid}, 128'b0);
    end
    check("stall_in_reset", {112'b0, stall_cnt}, 128'd0);
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    idle(LAT + 1);
    drive_cycle(1'b0, '0, '0, 2'b11, 10'd2, 10'd3, 2'b01, 64'h33);
    drive_cycle(1'b0, '0, '0, 2'b10, '0, 10'd3, 2'b10, 64'h44);

    // request raised and withdrawn inside a write cycle
    drive_cycle(1'b1, 10'd5, 64'h55, 2'b01, 10'd5, '0, 2'b00, '0);
    drive_cycle(1'b0, '0, '0, 2'b00, '0, '0, 2'b00, '0);
    check("stall_withdrawn", {112'b0, stall_cnt}, 128'd1);
    idle(LAT + 1);

    // long write-priority stall saturates
    wr_en    = 1'b1;
    wr_addr  = 10'd6;
    wr_data  = 64'h66;
    rd_ready = 2'b01;
    rd_addr  = {10'd0, 10'd6};
    repeat (70000) @(posedge core_clk);
    #1;
    check("stall_saturated", {112'b0, stall_cnt}, 128'hFFFF);
    drive_cycle(1'b0, '0, '0, 2'b01, 10'd6, '0, 2'b01, 64'h66);
    drive_cycle(1'b1, 10'd7, 64'h77, 2'b01, 10'd6, '0, 2'b00, '0);
    check("stall_no_rollover", {112'b0, stall_cnt}, 128'hFFFF);
    idle(1);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge core_clk);
    @(negedge core_clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
